// File: rtl/cu_prefetch_stream_responder.sv
// PSL command-side responder for the prefetch stream engines: tags each CU request,
// issues it to PSL, retries recoverable responses and returns completions to the CU.
package cu_prefetch_pkg;

    localparam int ARRAY_SIZE_BITS = 32;
    localparam int CU_ID_BITS      = 8;
    localparam int PSL_TAG_BITS    = 8;
    localparam int PSL_CMD_BITS    = 13;
    localparam int PSL_ADDR_BITS   = 64;
    localparam int PSL_SIZE_BITS   = 12;
    localparam int PSL_RSP_BITS    = 8;

    localparam logic [PSL_RSP_BITS-1:0] RSP_DONE    = 8'h00;
    localparam logic [PSL_RSP_BITS-1:0] RSP_AERROR  = 8'h01;
    localparam logic [PSL_RSP_BITS-1:0] RSP_DERROR  = 8'h03;
    localparam logic [PSL_RSP_BITS-1:0] RSP_NLOCK   = 8'h04;
    localparam logic [PSL_RSP_BITS-1:0] RSP_NRES    = 8'h05;
    localparam logic [PSL_RSP_BITS-1:0] RSP_FLUSHED = 8'h06;
    localparam logic [PSL_RSP_BITS-1:0] RSP_FAULT   = 8'h07;
    localparam logic [PSL_RSP_BITS-1:0] RSP_FAILED  = 8'h08;
    localparam logic [PSL_RSP_BITS-1:0] RSP_PAGED   = 8'h0A;

    typedef struct packed {
        logic [CU_ID_BITS-1:0]      cu_id;
        logic [1:0]                 cmd_type;
        logic [ARRAY_SIZE_BITS-1:0] real_size;
        logic [31:0]                address_offest;
        logic [1:0]                 array_struct;
        logic [2:0]                 abt;
    } CommandMetadata;

    typedef struct packed {
        logic                     valid;
        logic [PSL_CMD_BITS-1:0]  command;
        logic [PSL_ADDR_BITS-1:0] address;
        logic [PSL_SIZE_BITS-1:0] size;
        CommandMetadata           cmd;
    } CommandBufferLine;

    typedef struct packed {
        logic                     valid;
        logic [PSL_CMD_BITS-1:0]  command;
        logic [PSL_TAG_BITS-1:0]  tag;
        logic [PSL_ADDR_BITS-1:0] address;
        logic [PSL_SIZE_BITS-1:0] size;
        logic [2:0]               abt;
    } CommandInterfaceOutput;

    typedef struct packed {
        logic                    valid;
        logic [PSL_TAG_BITS-1:0] tag;
        logic [PSL_RSP_BITS-1:0] response;
    } ResponseInterface;

    typedef struct packed {
        logic           valid;
        CommandMetadata cmd;
    } ResponseBufferLine;

endpackage

module cu_prefetch_stream_responder
    import cu_prefetch_pkg::*;
#(
    parameter int TAG_COUNT       = 32,
    parameter int TAG_BITS        = $clog2(TAG_COUNT),
    parameter int DONE_COUNT_BITS = ARRAY_SIZE_BITS
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       enabled_in,
    input  CommandBufferLine           command_in,
    output logic                       command_ready,
    output CommandInterfaceOutput      psl_command_out,
    input  ResponseInterface           psl_response_in,
    output ResponseBufferLine          response_out,
    output logic [TAG_BITS:0]          outstanding_count,
    output logic [DONE_COUNT_BITS-1:0] done_counter,
    output logic                       error_flag,
    output logic                       protocol_error
);

    localparam logic [TAG_BITS:0] FULL_COUNT = (TAG_BITS + 1)'(TAG_COUNT);

    logic                  enabled_q;
    logic [TAG_COUNT-1:0]  free_map;
    CommandBufferLine      tag_table [TAG_COUNT];

    logic [TAG_BITS-1:0]   retry_fifo [TAG_COUNT];
    logic [TAG_BITS-1:0]   retry_wr;
    logic [TAG_BITS-1:0]   retry_rd;
    logic [TAG_BITS:0]     retry_cnt;

    logic                  issue_vld_p1;
    CommandInterfaceOutput issue_p1;
    logic                  resp_vld_p1;
    CommandMetadata        resp_cmd_p1;

    logic                  retry_empty;
    logic                  retry_pop;
    logic                  retry_push;
    logic                  cmd_fire;
    logic [TAG_BITS-1:0]   alloc_tag;
    logic [TAG_BITS-1:0]   rsp_tag;
    logic                  rsp_known;
    logic                  rsp_orphan;
    logic                  rsp_is_done;
    logic                  rsp_is_retry;
    logic                  rsp_release;

    function automatic CommandInterfaceOutput to_psl(input CommandBufferLine line,
                                                     input logic [TAG_BITS-1:0] tag);
        CommandInterfaceOutput c;
        c.valid   = line.valid;
        c.command = line.command;
        c.tag     = PSL_TAG_BITS'(tag);
        c.address = line.address;
        c.size    = line.size;
        c.abt     = line.cmd.abt;
        return c;
    endfunction

    // Lowest-index free tag from the pre-edge map.
    always_comb begin
        alloc_tag = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (free_map[i]) alloc_tag = TAG_BITS'(i);
        end
    end

    always_comb begin
        rsp_tag      = psl_response_in.tag[TAG_BITS-1:0];
        rsp_known    = psl_response_in.valid && (int'(psl_response_in.tag) < TAG_COUNT)
                       && !free_map[rsp_tag];
        rsp_orphan   = psl_response_in.valid && !rsp_known;
        rsp_is_done  = (psl_response_in.response == RSP_DONE);
        rsp_is_retry = (psl_response_in.response == RSP_PAGED)
                    || (psl_response_in.response == RSP_FLUSHED)
                    || (psl_response_in.response == RSP_NRES)
                    || (psl_response_in.response == RSP_NLOCK);
        rsp_release  = rsp_known && !rsp_is_retry;
        retry_push   = rsp_known && rsp_is_retry;
        retry_empty  = (retry_cnt == '0);
        retry_pop    = !retry_empty;
        // Ready is blocked while retries are pending, so accept and pop never collide.
        command_ready = enabled_q && (outstanding_count != FULL_COUNT) && retry_empty;
        cmd_fire     = command_in.valid && command_ready;
    end

    // Control state: enable, tag ownership, retry pointers, counters and flags.
    always_ff @(posedge clock) begin
        if (rst) begin
            enabled_q         <= 1'b0;
            free_map          <= '1;
            retry_wr          <= '0;
            retry_rd          <= '0;
            retry_cnt         <= '0;
            issue_vld_p1      <= 1'b0;
            resp_vld_p1       <= 1'b0;
            outstanding_count <= '0;
            done_counter      <= '0;
            error_flag        <= 1'b0;
            protocol_error    <= 1'b0;
        end else begin
            enabled_q <= enabled_in;
            if (rsp_release) free_map[rsp_tag] <= 1'b1;
            if (cmd_fire)    free_map[alloc_tag] <= 1'b0;
            outstanding_count <= outstanding_count + (TAG_BITS + 1)'(cmd_fire)
                                                   - (TAG_BITS + 1)'(rsp_release);
            retry_wr  <= retry_wr + TAG_BITS'(retry_push);
            retry_rd  <= retry_rd + TAG_BITS'(retry_pop);
            retry_cnt <= retry_cnt + (TAG_BITS + 1)'(retry_push) - (TAG_BITS + 1)'(retry_pop);
            issue_vld_p1 <= cmd_fire || retry_pop;
            resp_vld_p1  <= rsp_known && rsp_is_done;
            if (rsp_known && rsp_is_done)
                done_counter <= done_counter + DONE_COUNT_BITS'(tag_table[rsp_tag].cmd.real_size);
            if (rsp_known && !rsp_is_done && !rsp_is_retry) error_flag <= 1'b1;
            if (rsp_orphan) protocol_error <= 1'b1;
        end
    end

    // Stage p1: tag table, retry storage and the issue/completion payload registers.
    always_ff @(posedge clock) begin
        if (cmd_fire)   tag_table[alloc_tag] <= command_in;
        if (retry_push) retry_fifo[retry_wr] <= rsp_tag;
        if (retry_pop)
            issue_p1 <= to_psl(tag_table[retry_fifo[retry_rd]], retry_fifo[retry_rd]);
        else if (cmd_fire)
            issue_p1 <= to_psl(command_in, alloc_tag);
        if (rsp_known && rsp_is_done) resp_cmd_p1 <= tag_table[rsp_tag].cmd;
    end

    always_comb begin
        psl_command_out = '0;
        if (issue_vld_p1) psl_command_out = issue_p1;
        response_out = '0;
        if (resp_vld_p1) begin
            response_out.valid = 1'b1;
            response_out.cmd   = resp_cmd_p1;
        end
    end

endmodule

// File: tb/tb_cu_prefetch_stream_responder.sv
// Directed bench for cu_prefetch_stream_responder: allocation, completion, retry,
// error, orphan-response, enable and reset behaviour with hand-computed expectations.
module tb_cu_prefetch_stream_responder;
    import cu_prefetch_pkg::*;

    logic                  clock;
    logic                  rst;
    logic                  enabled_in;
    CommandBufferLine      command_in;
    logic                  command_ready;
    CommandInterfaceOutput psl_command_out;
    ResponseInterface      psl_response_in;
    ResponseBufferLine     response_out;
    logic [5:0]            outstanding_count;
    logic [31:0]           done_counter;
    logic                  error_flag;
    logic                  protocol_error;

    int checks = 0;
    int errors = 0;

    cu_prefetch_stream_responder #(.TAG_COUNT(32)) dut (
        .clock             (clock),
        .rst               (rst),
        .enabled_in        (enabled_in),
        .command_in        (command_in),
        .command_ready     (command_ready),
        .psl_command_out   (psl_command_out),
        .psl_response_in   (psl_response_in),
        .response_out      (response_out),
        .outstanding_count (outstanding_count),
        .done_counter      (done_counter),
        .error_flag        (error_flag),
        .protocol_error    (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] addr_of(input int idx);
        return 64'h1000 + 64'(idx) * 64'h80;
    endfunction

    function automatic CommandBufferLine mk(input int idx, input int real_size);
        CommandBufferLine l;
        l = '0;
        l.valid                  = 1'b1;
        l.command                = 13'h0A50;
        l.address                = addr_of(idx);
        l.size                   = 12'd128;
        l.cmd.cu_id              = 8'(idx);
        l.cmd.cmd_type           = 2'd1;
        l.cmd.real_size          = 32'(real_size);
        l.cmd.address_offest     = 32'h100 + 32'(idx) * 32'd4;
        l.cmd.array_struct       = 2'd2;
        l.cmd.abt                = 3'd1;
        return l;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input CommandBufferLine line);
        command_in = line;
        tick();
        command_in = '0;
    endtask

    task automatic send_rsp(input int tag, input logic [7:0] code);
        psl_response_in.valid    = 1'b1;
        psl_response_in.tag      = 8'(tag);
        psl_response_in.response = code;
        tick();
        psl_response_in = '0;
    endtask

    task automatic check_issue(input string name, input int tag, input int idx);
        check({name, "_valid"}, 64'(psl_command_out.valid), 64'd1);
        check({name, "_tag"}, 64'(psl_command_out.tag), 64'(tag));
        check({name, "_addr"}, psl_command_out.address, addr_of(idx));
    endtask

    task automatic check_resp(input string name, input int idx);
        check({name, "_valid"}, 64'(response_out.valid), 64'd1);
        check({name, "_cu_id"}, 64'(response_out.cmd.cu_id), 64'(8'(idx)));
        check({name, "_offset"}, 64'(response_out.cmd.address_offest),
              64'(32'h100 + 32'(idx) * 32'd4));
    endtask

    initial begin
        rst             = 1'b1;
        enabled_in      = 1'b1;
        command_in      = '0;
        psl_response_in = '0;
        tick();
        tick();
        check("rst_outstanding", 64'(outstanding_count), 64'd0);
        check("rst_psl", 64'(psl_command_out), 64'd0);
        check("rst_resp_valid", 64'(response_out.valid), 64'd0);
        check("rst_done", 64'(done_counter), 64'd0);
        check("rst_error", 64'(error_flag), 64'd0);
        check("rst_proto", 64'(protocol_error), 64'd0);
        check("rst_ready", 64'(command_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(command_ready), 64'd1);

        // Three commands, then an orphan response, then in-order DONEs.
        send_cmd(mk(0, 2));
        check_issue("t1_issue0", 0, 0);
        send_cmd(mk(1, 2));
        check_issue("t1_issue1", 1, 1);
        send_cmd(mk(2, 1));
        check_issue("t1_issue2", 2, 2);
        tick();
        check("t1_pulse", 64'(psl_command_out.valid), 64'd0);
        check("t1_outstanding3", 64'(outstanding_count), 64'd3);
        send_rsp(20, RSP_DONE);
        check("orphan_proto", 64'(protocol_error), 64'd1);
        check("orphan_outstanding", 64'(outstanding_count), 64'd3);
        check("orphan_no_resp", 64'(response_out.valid), 64'd0);
        send_rsp(0, RSP_DONE);
        check_resp("t1_resp0", 0);
        send_rsp(1, RSP_DONE);
        check_resp("t1_resp1", 1);
        send_rsp(2, RSP_DONE);
        check_resp("t1_resp2", 2);
        tick();
        check("t1_resp_pulse", 64'(response_out.valid), 64'd0);
        check("t1_done", 64'(done_counter), 64'd5);
        check("t1_outstanding0", 64'(outstanding_count), 64'd0);

        // AERROR on tag 1 frees it without a completion.
        send_cmd(mk(10, 4));
        check_issue("ae_issue0", 0, 10);
        send_cmd(mk(11, 3));
        check_issue("ae_issue1", 1, 11);
        send_rsp(1, RSP_AERROR);
        check("ae_error", 64'(error_flag), 64'd1);
        check("ae_no_resp", 64'(response_out.valid), 64'd0);
        check("ae_outstanding", 64'(outstanding_count), 64'd1);
        check("ae_done", 64'(done_counter), 64'd5);
        send_cmd(mk(12, 6));
        check_issue("ae_reuse1", 1, 12);
        send_rsp(0, RSP_DONE);
        send_rsp(1, RSP_DONE);
        check_resp("ae_resp12", 12);
        check("ae_done_total", 64'(done_counter), 64'd15);
        check("ae_outstanding0", 64'(outstanding_count), 64'd0);

        // Enable drops ready one cycle later.
        enabled_in = 1'b0;
        check("en_lag", 64'(command_ready), 64'd1);
        tick();
        check("en_off", 64'(command_ready), 64'd0);
        enabled_in = 1'b1;
        tick();
        check("en_on", 64'(command_ready), 64'd1);

        // PAGED on tag 3: retry goes out before the pending new command.
        for (int i = 0; i < 5; i++) begin
            send_cmd(mk(20 + i, 1));
            check_issue($sformatf("pg_fill%0d", i), i, 20 + i);
        end
        send_rsp(3, RSP_PAGED);
        check("pg_ready_low", 64'(command_ready), 64'd0);
        check("pg_no_resp", 64'(response_out.valid), 64'd0);
        check("pg_outstanding", 64'(outstanding_count), 64'd5);
        command_in = mk(30, 1);
        tick();
        check_issue("pg_retry", 3, 23);
        check("pg_ready_back", 64'(command_ready), 64'd1);
        tick();
        command_in = '0;
        check_issue("pg_new", 5, 30);
        check("pg_outstanding6", 64'(outstanding_count), 64'd6);
        send_rsp(3, RSP_DONE);
        check_resp("pg_resp", 23);
        check("pg_done", 64'(done_counter), 64'd16);
        tick();
        check("pg_single_resp", 64'(response_out.valid), 64'd0);
        check("pg_outstanding5", 64'(outstanding_count), 64'd5);

        // Reset with five tags in flight.
        rst = 1'b1;
        tick();
        check("rst2_outstanding", 64'(outstanding_count), 64'd0);
        check("rst2_psl", 64'(psl_command_out), 64'd0);
        check("rst2_resp", 64'(response_out), 64'd0);
        check("rst2_done", 64'(done_counter), 64'd0);
        check("rst2_error", 64'(error_flag), 64'd0);
        check("rst2_proto", 64'(protocol_error), 64'd0);
        rst = 1'b0;
        tick();
        check("rst2_ready", 64'(command_ready), 64'd1);
        send_rsp(2, RSP_DONE);
        check("rst2_stale_proto", 64'(protocol_error), 64'd1);
        check("rst2_stale_resp", 64'(response_out.valid), 64'd0);
        check("rst2_stale_outstanding", 64'(outstanding_count), 64'd0);

        // Fill all 32 tags, then free tag 7 and reallocate it.
        for (int i = 0; i < 32; i++) begin
            command_in = mk(40 + i, 1);
            tick();
            check($sformatf("full_tag%0d", i), 64'(psl_command_out.tag), 64'(i));
        end
        command_in = mk(80, 1);
        check("full_outstanding", 64'(outstanding_count), 64'd32);
        check("full_ready_low", 64'(command_ready), 64'd0);
        send_rsp(7, RSP_DONE);
        check("full_ready_back", 64'(command_ready), 64'd1);
        check("full_outstanding31", 64'(outstanding_count), 64'd31);
        check("full_no_issue", 64'(psl_command_out.valid), 64'd0);
        check_resp("full_resp7", 47);
        tick();
        command_in = '0;
        check_issue("full_realloc7", 7, 80);
        check("full_outstanding32", 64'(outstanding_count), 64'd32);
        check("full_ready_low2", 64'(command_ready), 64'd0);
        check("full_done", 64'(done_counter), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_prefetch_stream_responder.md
Name: cu_prefetch_stream_responder

Overview:
- Command-side responder for the prefetch stream engines. Accepts CommandBufferLine requests issued by a prefetch control unit, assigns a PSL tag to each, drives the PSL command interface, and tracks every tag until its PSL response returns.
- Completed requests come back to the requesting CU as ResponseBufferLine, carrying the original cmd metadata: cu_id, cmd_type, real_size, address_offest, array_struct, abt.
- Retryable PSL responses (PAGED, FLUSHED, NRES, NLOCK) are re-issued with the same tag. All other non-DONE responses are retired as errors.

Parameters:
- TAG_COUNT, 32: number of in-flight tags; power of two, 4..256.
- TAG_BITS, $clog2(TAG_COUNT): tag index width.
- DONE_COUNT_BITS, ARRAY_SIZE_BITS: width of the completed real_size accumulator.

Ports:
- clock  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enabled_in  in  1  block enable; registered once internally (enabled_q).
- command_in  in  CommandBufferLine  request from prefetch control; consumed when command_in.valid && command_ready.
- command_ready  out  1  accept permission; driven only from registered state.
- psl_command_out  out  CommandInterfaceOutput  PSL command: valid, command, tag, address, size, abt.
- psl_response_in  in  ResponseInterface  PSL response: valid, tag, response code.
- response_out  out  ResponseBufferLine  completion back to the CU: valid plus stored cmd.
- outstanding_count  out  TAG_BITS+1  tags currently allocated.
- done_counter  out  DONE_COUNT_BITS  sum of cmd.real_size over DONE completions.
- error_flag  out  1  sticky; set on any non-retryable response.
- protocol_error  out  1  sticky; set on a response for an unallocated tag.

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - All outputs, counters and sticky flags go to 0.
  - The tag free-map is all free; the retry FIFO is empty.
  - In-flight state is discarded; PSL responses arriving after reset count as unallocated tags.
- command_ready = enabled_q && (free_count != 0) && retry FIFO empty.
- Accept and allocate:
  - On accept, the lowest-index free tag, taken from the pre-edge free-map, is allocated.
  - The full CommandBufferLine is stored in tag_table[tag].
  - Next cycle psl_command_out drives valid=1, tag, command, address, size and abt copied from command_in. Latency from accept to issue is 1 cycle.
- Issue slot:
  - psl_command_out.valid is a 1-cycle pulse per issue; otherwise the whole struct is 0.
  - At most one issue per cycle. A pending retry always wins over a new command.
- Retry:
  - The retry FIFO has depth TAG_COUNT and cannot overflow.
  - When it is non-empty, the head tag is popped and psl_command_out is re-driven from tag_table[head], same tag, 1 cycle after the pop.
- Response handling (registered; acts 1 cycle after psl_response_in.valid):
  - DONE: response_out.valid=1 and response_out.cmd=tag_table[tag].cmd. The tag is freed and done_counter += cmd.real_size (wraps modulo 2^DONE_COUNT_BITS).
  - PAGED / FLUSHED / NRES / NLOCK: the tag stays allocated and is pushed into the retry FIFO. No response_out.
  - Any other code (AERROR, DERROR, FAILED, FAULT, ...): the tag is freed, error_flag is set, and no response_out is produced.
  - Tag not allocated: ignored, protocol_error is set, and no state change.
- Simultaneous events:
  - Accept and free in the same cycle: both take effect, so outstanding_count is net unchanged.
  - A tag freed at edge N is allocatable no earlier than edge N+1.
  - Retry push and pop in the same cycle are both honored.
- outstanding_count: incremented on allocation, decremented on free. It never exceeds TAG_COUNT.
- enabled_in deasserted: command_ready drops 1 cycle later (registered enable). In-flight tags and retries still complete, and response handling continues.
- Ordering: responses are returned in PSL response order, not command order.

Test Plan:
- Reset then 3 commands with real_size 2,2,1 and PSL DONE in order -> tags 0,1,2 issued 1 cycle after each accept; 3 response_out pulses with matching cu_id/address_offest; done_counter=5; outstanding_count returns to 0.
- Issue TAG_COUNT=32 commands with no responses -> command_ready=0 once outstanding_count=32; one DONE on tag 7 -> ready rises the next cycle; the next accept gets tag 7.
- PAGED on tag 3 while new commands pending -> retry of tag 3 (same address) issued before any new command; ready low while the retry FIFO is non-empty; a later DONE on tag 3 yields exactly one response_out.
- AERROR on tag 1 -> error_flag=1, no response_out, tag 1 freed, done_counter unchanged.
- Response with tag 20 when only tags 0-2 are allocated -> protocol_error=1, outstanding_count unchanged.
- Assert rst with 5 tags in flight -> next cycle all outputs 0, outstanding_count=0, command_ready high once enabled_q=1.
